// File: rtl/alu_acc_flags_mc_pkg.sv
`default_nettype none
// ============================================================================
// alu_acc_flags_mc_pkg
// Shared enums and helpers for the multi-cycle accumulator ALU.
// Revision: 1.0
// ============================================================================
package alu_acc_flags_mc_pkg;

  typedef enum logic [1:0] {
    SRC_IMM = 2'd0,
    SRC_REG = 2'd1,
    SRC_MEM = 2'd2
  } data_src_t;

  // Codes 12..15 are reserved and execute as a NOP.
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADC  = 4'd1,
    OP_SUB  = 4'd2,
    OP_SBC  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_LD   = 4'd7,
    OP_MUL  = 4'd8,
    OP_SHLN = 4'd9,
    OP_SHRN = 4'd10,
    OP_ASRN = 4'd11
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } seq_state_t;

  function automatic logic is_multicycle(alu_op_t op);
    return (op == OP_MUL) || (op == OP_SHLN) || (op == OP_SHRN) || (op == OP_ASRN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_acc_flags_mc_if.sv
`default_nettype none
// ============================================================================
// alu_acc_flags_mc_if
// Operand, request and result bundle between the control unit and the ALU.
// Revision: 1.0
// ============================================================================
interface alu_acc_flags_mc_if
  import alu_acc_flags_mc_pkg::*;
#(
  parameter int WIDTH = 8
);
  data_src_t        data_src;
  logic [WIDTH-1:0] immediate;
  logic [WIDTH-1:0] reg_out;
  logic [WIDTH-1:0] mem_out;
  alu_op_t          op;
  logic             start;
  logic             ce_cy;
  logic [WIDTH-1:0] alu_in;
  logic [WIDTH-1:0] acc_v;
  logic [WIDTH-1:0] acc_hi;
  logic             busy;
  logic             done;
  logic             flag_cy;
  logic             flag_z;
  logic             flag_s;
  logic             flag_o;

  modport master (
    output data_src, immediate, reg_out, mem_out, op, start, ce_cy,
    input  alu_in, acc_v, acc_hi, busy, done, flag_cy, flag_z, flag_s, flag_o
  );

  modport slave (
    input  data_src, immediate, reg_out, mem_out, op, start, ce_cy,
    output alu_in, acc_v, acc_hi, busy, done, flag_cy, flag_z, flag_s, flag_o
  );
endinterface
`default_nettype wire

// File: rtl/alu_acc_flags_mc_seq_unit.sv
`default_nettype none
// ============================================================================
// alu_seq_unit
// One-step-per-clock shift-add multiplier and N-bit shifter with step counter.
// Revision: 1.0
// ============================================================================
module alu_seq_unit
  import alu_acc_flags_mc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       launch,
  input  alu_op_t                    op,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic [$clog2(WIDTH)-1:0]   count,
  output logic                       busy,
  output logic                       finish,
  output logic [WIDTH-1:0]           res_lo,
  output logic [WIDTH-1:0]           res_hi,
  output logic                       cy_out
);

  localparam int CNTW = $clog2(WIDTH) + 1;

  seq_state_t       state_q, state_d;
  alu_op_t          op_q, op_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, mc_q, mc_d;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic             step_cy;
  logic [WIDTH:0]   mul_sum;

  // One iteration; on the final step this is also the result handed to the top.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mc_q} : {(WIDTH+1){1'b0}});
    step_hi = hi_q;
    step_lo = lo_q;
    step_cy = 1'b0;
    case (op_q)
      OP_MUL: begin
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
      OP_SHLN: begin
        step_lo = {lo_q[WIDTH-2:0], 1'b0};
        step_cy = lo_q[WIDTH-1];
      end
      OP_SHRN: begin
        step_lo = {1'b0, lo_q[WIDTH-1:1]};
        step_cy = lo_q[0];
      end
      OP_ASRN: begin
        step_lo = {lo_q[WIDTH-1], lo_q[WIDTH-1:1]};
        step_cy = lo_q[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mc_d    = mc_q;
    case (state_q)
      S_RUN: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) state_d = S_FINISH;
      end
      default: begin
        state_d = S_IDLE;
        if (launch) begin
          state_d = S_RUN;
          op_d    = op;
          hi_d    = '0;
          if (op == OP_MUL) begin
            lo_d  = b;
            mc_d  = a;
            cnt_d = CNTW'(WIDTH);
          end else begin
            lo_d  = a;
            mc_d  = '0;
            cnt_d = {1'b0, count};
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mc_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mc_q    <= mc_d;
    end
  end

  assign busy   = (state_q == S_RUN);
  assign finish = busy && (cnt_q == CNTW'(1));
  assign res_lo = step_lo;
  assign res_hi = step_hi;
  assign cy_out = step_cy;

endmodule
`default_nettype wire

// File: rtl/alu_acc_flags_mc.sv
`default_nettype none
// ============================================================================
// alu_acc_flags_mc
// Accumulator ALU with flags, single-cycle ops and iterative MUL/shift ops.
// Revision: 1.0
// ============================================================================
module alu_acc_flags_mc
  import alu_acc_flags_mc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  alu_acc_flags_mc_if.slave bus
);

  localparam int CW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] alu_in;
  logic [WIDTH-1:0] acc_q, acc_d, acc_hi_q, acc_hi_d;
  logic             cy_q, cy_d, z_q, z_d, s_q, s_d, o_q, o_d;
  logic             done_q, done_d, run_ce_q, run_ce_d;
  alu_op_t          run_op_q, run_op_d;
  logic             accept, launch, shift_zero, cin, zs_upd;
  logic [WIDTH:0]   add_res, sub_res;
  logic             seq_busy, seq_finish, seq_cy;
  logic [WIDTH-1:0] seq_lo, seq_hi;

  always_comb begin
    case (bus.data_src)
      SRC_REG: alu_in = bus.reg_out;
      SRC_MEM: alu_in = bus.mem_out;
      default: alu_in = bus.immediate;
    endcase
  end

  // A zero-count shift never enters the engine; it completes like a single-cycle op.
  assign shift_zero = ((bus.op == OP_SHLN) || (bus.op == OP_SHRN) || (bus.op == OP_ASRN))
                      && (alu_in[CW-1:0] == '0);
  assign accept  = bus.start && !seq_busy;
  assign launch  = accept && is_multicycle(bus.op) && !shift_zero;
  assign cin     = ((bus.op == OP_ADC) || (bus.op == OP_SBC)) ? cy_q : 1'b0;
  assign add_res = {1'b0, acc_q} + {1'b0, alu_in} + {{WIDTH{1'b0}}, cin};
  assign sub_res = {1'b0, acc_q} - {1'b0, alu_in} - {{WIDTH{1'b0}}, cin};

  alu_seq_unit #(.WIDTH(WIDTH)) u_seq (
    .clk    (clk),
    .rst    (rst),
    .launch (launch),
    .op     (bus.op),
    .a      (acc_q),
    .b      (alu_in),
    .count  (alu_in[CW-1:0]),
    .busy   (seq_busy),
    .finish (seq_finish),
    .res_lo (seq_lo),
    .res_hi (seq_hi),
    .cy_out (seq_cy)
  );

  always_comb begin
    acc_d    = acc_q;
    acc_hi_d = acc_hi_q;
    cy_d     = cy_q;
    z_d      = z_q;
    s_d      = s_q;
    o_d      = o_q;
    done_d   = 1'b0;
    run_op_d = run_op_q;
    run_ce_d = run_ce_q;
    zs_upd   = 1'b0;
    if (accept) begin
      run_op_d = bus.op;
      run_ce_d = bus.ce_cy;
      done_d   = !launch;
      if (!launch) begin
        zs_upd = 1'b1;
        case (bus.op)
          OP_ADD, OP_ADC: begin
            acc_d = add_res[MSB:0];
            o_d   = (acc_q[MSB] == alu_in[MSB]) && (add_res[MSB] != acc_q[MSB]);
            if (bus.ce_cy) cy_d = add_res[WIDTH];
          end
          OP_SUB, OP_SBC: begin
            acc_d = sub_res[MSB:0];
            o_d   = (acc_q[MSB] != alu_in[MSB]) && (sub_res[MSB] != acc_q[MSB]);
            if (bus.ce_cy) cy_d = sub_res[WIDTH];
          end
          OP_AND: begin acc_d = acc_q & alu_in; o_d = 1'b0; end
          OP_OR:  begin acc_d = acc_q | alu_in; o_d = 1'b0; end
          OP_XOR: begin acc_d = acc_q ^ alu_in; o_d = 1'b0; end
          OP_LD:  begin acc_d = alu_in;         o_d = 1'b0; end
          OP_SHLN, OP_SHRN, OP_ASRN: o_d = 1'b0;
          default: zs_upd = 1'b0;
        endcase
        if (zs_upd) begin
          z_d = (acc_d == '0);
          s_d = acc_d[MSB];
        end
      end
    end
    if (seq_finish) begin
      done_d = 1'b1;
      acc_d  = seq_lo;
      if (run_op_q == OP_MUL) begin
        acc_hi_d = seq_hi;
        z_d      = ({seq_hi, seq_lo} == '0);
        s_d      = seq_hi[MSB];
        o_d      = |seq_hi;
        if (run_ce_q) cy_d = |seq_hi;
      end else begin
        z_d = (seq_lo == '0);
        s_d = seq_lo[MSB];
        o_d = 1'b0;
        if (run_ce_q) cy_d = seq_cy;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      acc_hi_q <= '0;
      cy_q     <= 1'b0;
      z_q      <= 1'b0;
      s_q      <= 1'b0;
      o_q      <= 1'b0;
      done_q   <= 1'b0;
      run_op_q <= OP_ADD;
      run_ce_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      acc_hi_q <= acc_hi_d;
      cy_q     <= cy_d;
      z_q      <= z_d;
      s_q      <= s_d;
      o_q      <= o_d;
      done_q   <= done_d;
      run_op_q <= run_op_d;
      run_ce_q <= run_ce_d;
    end
  end

  assign bus.alu_in  = alu_in;
  assign bus.acc_v   = acc_q;
  assign bus.acc_hi  = acc_hi_q;
  assign bus.busy    = seq_busy;
  assign bus.done    = done_q;
  assign bus.flag_cy = cy_q;
  assign bus.flag_z  = z_q;
  assign bus.flag_s  = s_q;
  assign bus.flag_o  = o_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_acc_flags_mc.sv
`default_nettype none
// ============================================================================
// tb_alu_acc_flags_mc
// Table vectors, hand-written corner sequences and randomized ops vs a model.
// Revision: 1.0
// ============================================================================
module tb_alu_acc_flags_mc;
  import alu_acc_flags_mc_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_acc_flags_mc_if #(.WIDTH(W)) bus ();
  alu_acc_flags_mc #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  int m_acc, m_hi;
  bit m_cy, m_z, m_s, m_o;

  typedef struct {
    int         opc;
    int         val;
    bit         ce;
    int         src;
    logic [7:0] acc;
    logic [7:0] hi;
    logic [3:0] fl;
    int         busy;
  } vec_t;

  vec_t tbl[28];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_state();
    return 32'({bus.acc_v, bus.acc_hi, bus.flag_cy, bus.flag_z, bus.flag_s, bus.flag_o});
  endfunction

  function automatic logic [31:0] model_state();
    logic [7:0] a, h;
    a = 8'(m_acc);
    h = 8'(m_hi);
    return 32'({a, h, m_cy, m_z, m_s, m_o});
  endfunction

  function automatic void model_reset();
    m_acc = 0; m_hi = 0; m_cy = 0; m_z = 0; m_s = 0; m_o = 0;
  endfunction

  // Applies one op to the architectural state; returns expected busy cycles.
  function automatic int model_apply(input int opc, input int b, input bit ce);
    int mx, half, cin, r, sa, sb, sr, n, busy_cyc;
    longint p;
    mx = 1 << W;
    half = mx / 2;
    busy_cyc = 0;
    if (opc >= 12) return 0;
    sa = (m_acc >= half) ? m_acc - mx : m_acc;
    sb = (b >= half) ? b - mx : b;
    cin = ((opc == 1) || (opc == 3)) ? int'(m_cy) : 0;
    case (opc)
      0, 1: begin
        r = m_acc + b + cin;
        sr = sa + sb + cin;
        if (ce) m_cy = (r >= mx);
        m_o = (sr >= half) || (sr < -half);
        m_acc = r % mx;
      end
      2, 3: begin
        r = m_acc - b - cin;
        sr = sa - sb - cin;
        if (ce) m_cy = (r < 0);
        m_o = (sr >= half) || (sr < -half);
        m_acc = (r + mx) % mx;
      end
      4: begin m_acc = m_acc & b; m_o = 0; end
      5: begin m_acc = m_acc | b; m_o = 0; end
      6: begin m_acc = m_acc ^ b; m_o = 0; end
      7: begin m_acc = b; m_o = 0; end
      8: begin
        p = longint'(m_acc) * longint'(b);
        m_hi = int'(p / mx);
        m_acc = int'(p % mx);
        m_o = (m_hi != 0);
        if (ce) m_cy = m_o;
        busy_cyc = W;
      end
      default: begin
        n = b % W;
        m_o = 0;
        if (n > 0) begin
          busy_cyc = n;
          if (opc == 9) begin
            if (ce) m_cy = ((m_acc >> (W - n)) & 1) != 0;
            m_acc = (m_acc << n) % mx;
          end else if (opc == 10) begin
            if (ce) m_cy = ((m_acc >> (n - 1)) & 1) != 0;
            m_acc = m_acc >> n;
          end else begin
            if (ce) m_cy = ((sa >>> (n - 1)) & 1) != 0;
            m_acc = ((sa >>> n) + mx) % mx;
          end
        end
      end
    endcase
    if (opc == 8) begin
      m_z = (m_acc == 0) && (m_hi == 0);
      m_s = ((m_hi >> (W - 1)) & 1) != 0;
    end else begin
      m_z = (m_acc == 0);
      m_s = ((m_acc >> (W - 1)) & 1) != 0;
    end
    return busy_cyc;
  endfunction

  // Called at a negedge; returns at the negedge where done is expected.
  task automatic do_op(input int opc, input int val, input bit ce, input int src,
                       input int poke_at, output int cyc);
    int exp_busy;
    bit early;
    logic [3:0] o4;
    logic [1:0] s2;
    logic [7:0] v8;
    o4 = opc[3:0];
    s2 = src[1:0];
    v8 = val[7:0];
    bus.op        = alu_op_t'(o4);
    bus.data_src  = data_src_t'(s2);
    bus.immediate = 8'($urandom);
    bus.reg_out   = 8'($urandom);
    bus.mem_out   = 8'($urandom);
    case (src)
      1:       bus.reg_out   = v8;
      2:       bus.mem_out   = v8;
      default: bus.immediate = v8;
    endcase
    bus.ce_cy = ce;
    bus.start = 1'b1;
    #1;
    check("alu_in", 32'(bus.alu_in), 32'(v8));
    exp_busy = model_apply(opc, val, ce);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    early = 0;
    while (bus.busy === 1'b1 && cyc < 200) begin
      cyc++;
      if (bus.done !== 1'b0) early = 1;
      bus.immediate = 8'($urandom);
      bus.reg_out   = 8'($urandom);
      bus.mem_out   = 8'($urandom);
      if (cyc == poke_at) begin
        bus.op = OP_ADD;
        bus.data_src = SRC_IMM;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("busy_cycles", 32'(cyc), 32'(exp_busy));
    check("done_pulse", 32'({early, bus.done}), 32'(2'b01));
    check("model_state", dut_state(), model_state());
  endtask

  initial begin
    int cyc;
    bit seen;

    tbl[0]  = '{7,  'h01, 1, 0, 8'h01, 8'h00, 4'b0000, 0};
    tbl[1]  = '{0,  'h7F, 1, 0, 8'h80, 8'h00, 4'b0011, 0};
    tbl[2]  = '{7,  'h05, 1, 2, 8'h05, 8'h00, 4'b0000, 0};
    tbl[3]  = '{2,  'h05, 1, 0, 8'h00, 8'h00, 4'b0100, 0};
    tbl[4]  = '{7,  'h03, 1, 1, 8'h03, 8'h00, 4'b0000, 0};
    tbl[5]  = '{2,  'h05, 1, 0, 8'hFE, 8'h00, 4'b1010, 0};
    tbl[6]  = '{7,  'h12, 1, 0, 8'h12, 8'h00, 4'b1000, 0};
    tbl[7]  = '{8,  'h34, 1, 1, 8'hA8, 8'h03, 4'b1001, 8};
    tbl[8]  = '{7,  'h81, 1, 0, 8'h81, 8'h03, 4'b1010, 0};
    tbl[9]  = '{10, 'h03, 1, 0, 8'h10, 8'h03, 4'b0000, 3};
    tbl[10] = '{7,  'h81, 1, 0, 8'h81, 8'h03, 4'b0010, 0};
    tbl[11] = '{11, 'h01, 1, 2, 8'hC0, 8'h03, 4'b1010, 1};
    tbl[12] = '{9,  'h00, 1, 0, 8'hC0, 8'h03, 4'b1010, 0};
    tbl[13] = '{7,  'hFF, 1, 0, 8'hFF, 8'h03, 4'b1010, 0};
    tbl[14] = '{0,  'h01, 1, 0, 8'h00, 8'h03, 4'b1100, 0};
    tbl[15] = '{7,  'hFF, 0, 0, 8'hFF, 8'h03, 4'b1010, 0};
    tbl[16] = '{0,  'h01, 0, 0, 8'h00, 8'h03, 4'b1100, 0};
    tbl[17] = '{1,  'h00, 1, 0, 8'h01, 8'h03, 4'b0000, 0};
    tbl[18] = '{2,  'h02, 0, 1, 8'hFF, 8'h03, 4'b0010, 0};
    tbl[19] = '{13, 'h42, 1, 0, 8'hFF, 8'h03, 4'b0010, 0};
    tbl[20] = '{6,  'h0F, 1, 0, 8'hF0, 8'h03, 4'b0010, 0};
    tbl[21] = '{3,  'hF0, 1, 2, 8'h00, 8'h03, 4'b0100, 0};
    tbl[22] = '{5,  'h80, 1, 0, 8'h80, 8'h03, 4'b0010, 0};
    tbl[23] = '{4,  'h0F, 1, 0, 8'h00, 8'h03, 4'b0100, 0};
    tbl[24] = '{8,  'h55, 1, 0, 8'h00, 8'h00, 4'b0100, 8};
    tbl[25] = '{7,  'h0B, 1, 0, 8'h0B, 8'h00, 4'b0000, 0};
    tbl[26] = '{9,  'h05, 1, 0, 8'h60, 8'h00, 4'b1000, 5};
    tbl[27] = '{0,  'h7F, 1, 0, 8'hDF, 8'h00, 4'b0011, 0};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.ce_cy = 1'b0;
    bus.op = OP_ADD;
    bus.data_src = SRC_IMM;
    bus.immediate = '0;
    bus.reg_out = '0;
    bus.mem_out = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_state", 32'({dut_state(), bus.busy, bus.done}), 32'(0));

    foreach (tbl[i]) begin
      do_op(tbl[i].opc, tbl[i].val, tbl[i].ce, tbl[i].src, -1, cyc);
      check($sformatf("tbl%0d_state", i), dut_state(),
            32'({tbl[i].acc, tbl[i].hi, tbl[i].fl}));
      check($sformatf("tbl%0d_busy", i), 32'(cyc), 32'(tbl[i].busy));
    end

    // A start raised while the multiplier runs must be dropped.
    do_op(7, 'h9D, 1, 0, -1, cyc);
    do_op(8, 'hC3, 1, 1, 2, cyc);
    check("ignored_add_busy", 32'(cyc), 32'(W));

    // Reset in the middle of a multiply discards it without a done pulse.
    bus.op = OP_MUL;
    bus.data_src = SRC_IMM;
    bus.immediate = 8'hEE;
    bus.ce_cy = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_op", 32'({dut_state(), bus.busy, bus.done}), 32'(0));
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen = 1;
    end
    check("rst_no_done", 32'(seen), 32'(0));
    model_reset();

    for (int k = 0; k < 80; k++) begin
      do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
            bit'($urandom_range(0, 1)), int'($urandom_range(0, 2)), -1, cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_acc_flags_mc.md
Name: alu_acc_flags_mc

Overview:
Parametrised, multi-cycle successor of the accumulator ALU. It keeps the single-cycle ops: add/sub with and without carry, the logic ops and load. It adds an iterative unsigned multiply and N-bit shifts, executed one step per clock. A start/busy/done handshake connects it to the control FSM. The block sits between the operand sources (immediate, register file, memory) and the control unit, and owns the accumulator and the flag register.

Parameters:
WIDTH, 8, datapath width in bits (≥4, power of two)
CW, $clog2(WIDTH), shift-count width (derived, do not override)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
data_src  in  data_src_t  operand select: immediate / reg_out / mem_out
immediate  in  WIDTH  immediate operand
reg_out  in  WIDTH  register-file operand
mem_out  in  WIDTH  memory operand
op  in  alu_op_t (4)  operation, sampled with start
start  in  1  request; accepted only when busy=0
ce_cy  in  1  carry-flag write enable
alu_in  out  WIDTH  combinational selected operand
acc_v  out  WIDTH  accumulator
acc_hi  out  WIDTH  upper half of last MUL product
busy  out  1  multi-cycle op in progress
done  out  1  one-cycle completion pulse
flag_cy, flag_z, flag_s, flag_o  out  1 each  carry, zero, sign, signed-overflow flags

Behaviour:
- Reset, and rst=1 at any edge including mid-operation: acc_v, acc_hi, all flags, busy, done and internal counters go to 0. The in-flight op is discarded with no done pulse.
- alu_in is the combinational mux of the three sources by data_src. At acceptance the operand and op are latched, so sources may change while busy.
- Acceptance: start=1 and busy=0 at a rising edge. A start with busy=1 is ignored, with no queuing.
- Single-cycle ops (ADD, ADC, SUB, SBC, AND, OR, XOR, LD):
  - acc_v and flags are written at the accepting edge.
  - done=1 for the following cycle; busy stays 0.
  - Back-to-back start every cycle is legal.
- MUL (unsigned WIDTH×WIDTH, shift-add):
  - busy=1 for exactly WIDTH cycles after acceptance.
  - On the edge ending the last cycle: {acc_hi, acc_v} = product, busy drops to 0 and done=1 in the same cycle.
- SHLN / SHRN / ASRN:
  - Count n = operand[CW-1:0]; shift one bit per cycle; busy=1 for n cycles, then done as for MUL.
  - n=0 behaves as a single-cycle op: acc_v unchanged, z/s refreshed, cy unchanged.
- acc_v and acc_hi hold their old values until completion. Intermediate values live in internal working registers only.
- Flag rules, applied at completion:
  - z = (acc_v==0); for MUL, z = (full product==0).
  - s = acc_v[WIDTH-1]; for MUL, s = acc_hi[WIDTH-1].
  - ADD/ADC: cy = carry-out; o = signed overflow.
  - SUB/SBC: cy = borrow (acc < operand + cin); o = signed overflow. ADC/SBC use the current flag_cy as cin.
  - AND/OR/XOR/LD: cy unchanged; o = 0.
  - MUL: cy = o = (acc_hi != 0).
  - Shifts: cy = last bit shifted out; o = 0. ASRN replicates the MSB.
  - cy is written only if ce_cy=1 at acceptance; ce_cy is latched with op.
- Reserved op codes: treated as a NOP. done pulses; acc_v and flags are unchanged.
- done never coincides with acceptance of a new op in the same cycle for multi-cycle ops. A new start is legal in the done cycle.

Decomposition:
- Shared package, extending the existing enums header:
  - alu_op_t, a 4-bit enum: ADD, ADC, SUB, SBC, AND, OR, XOR, LD, MUL, SHLN, SHRN, ASRN, rest reserved.
  - is_multicycle() function.
  - Existing data_src_t reused unchanged.
- One sub-module: alu_seq_unit. It holds the multiply/shift iteration engine, step counter and IDLE/RUN/FINISH FSM, and returns result, carry-out and finish.
- The top level keeps the operand mux, single-cycle ALU, accumulator, flags and handshake.

Test Plan (WIDTH=8):
1. Reset, then LD imm 0x01; ADD imm 0x7F → acc_v=0x80, s=1, o=1, cy=0, z=0, done one cycle after the accepting edge, busy never high.
2. Reset, then LD 0x05; SUB 0x05 → acc_v=0x00, z=1, cy=0. Then LD 0x03; SUB 0x05 → acc_v=0xFE, cy=1, s=1.
3. LD 0x12; MUL reg_out=0x34 → busy high exactly 8 cycles, then acc_hi=0x03, acc_v=0xA8, cy=o=1, done on busy fall. Changing reg_out mid-op has no effect.
4. LD 0x81; SHRN by 3 → after 3 busy cycles acc_v=0x10, cy=0. Then LD 0x81; ASRN by 1 → acc_v=0xC0, cy=1. SHLN by 0 → no busy, done next cycle, acc_v unchanged.
5. start MUL, then start ADD at cycle 3 → ADD ignored, MUL result intact. Then a new MUL with rst=1 at cycle 4 → next cycle all outputs 0, busy=0, no done.
6. Set cy=1, then ce_cy=0; LD 0xFF; ADD 0x01 → acc_v=0x00, z=1, cy stays 1. Then ADC 0x00 with ce_cy=1 → acc_v=0x01, cy=0.
